fir_seq_ctrl: RTL and testbench



---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_seq_ctrl_if.sv | 24 ++
 rtl/fir_valid_delay.sv | 34 +++
 rtl/fir_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front-end sequencer.
// Holds the sequencer state encoding, default widths/tap count and the
// fixed FIR latency (fir_tvalid -> matching fir_y_n valid).
package fir_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_IDLE   = 2'b01,
    ST_LOAD   = 2'b10,
    ST_STREAM = 2'b11
  } fir_state_e;

  localparam int X_N_SIZE_DEF     = 8;
  localparam int Y_N_SIZE_DEF     = 11;
  localparam int NBR_OF_TAPS_DEF  = 3;
  localparam int SETUP_CYCLES_DEF = 4;
  localparam int FIR_LAT          = 2;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Host word stream into the FIR sequencer.
// Ports (signals):
//   in_data    - host word (coefficient or sample)
//   in_is_coef - 1 = coefficient, 0 = sample
//   in_valid   - host word valid
//   in_ready   - sequencer accepts the word this cycle
// Handshake: a word transfers on every rising clk edge where in_valid and
// in_ready are both 1. The host may change in_data/in_is_coef freely while
// in_valid is 0; in_ready does not depend on in_valid.
interface fir_seq_ctrl_if
  import fir_pkg::*;
#(
  parameter int X_N_SIZE = X_N_SIZE_DEF
) ();

  logic [X_N_SIZE-1:0] in_data;
  logic                in_is_coef;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_is_coef, output in_valid, input in_ready);
  modport slave  (input in_data, input in_is_coef, input in_valid, output in_ready);

endinterface

// File: rtl/fir_valid_delay.sv
// DEPTH-stage valid shift register with synchronous clear.
// Ports:
//   clk   - clock
//   clr_i - synchronous clear, empties every stage
//   in_i  - valid bit entering stage 0
//   out_o - valid bit leaving the last stage (in_i delayed DEPTH cycles)
//   any_o - 1 while any stage holds a pending valid
module fir_valid_delay
  import fir_pkg::*;
#(
  parameter int DEPTH = FIR_LAT
) (
  input  logic clk,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o,
  output logic any_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift written as a left shift so DEPTH=1 needs no special case.
  assign sr_d = (sr_q << 1) | DEPTH'(in_i);

  always_ff @(posedge clk) begin
    if (clr_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign out_o = sr_q[DEPTH-1];
  assign any_o = |sr_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Front-end sequencer for the adaptive-coefficient FIR datapath.
// Turns a tagged host word stream into the FIR's raw control pins, covers the
// FIR's post-reset setup window and realigns y_n into a valid-qualified stream.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   host           - host word stream (slave side of fir_seq_ctrl_if)
//   fir_x_n        - word to FIR x_n (holds when nothing accepted)
//   fir_tvalid     - sample strobe to FIR s_axis_fir_tvalid
//   fir_set_coeffs - coefficient shift strobe to FIR s_set_coeffs
//   fir_reset      - active-high FIR reset
//   fir_y_n        - FIR output
//   out_data       - filtered result, fir_y_n gated by out_valid (0 otherwise)
//   out_valid      - one pulse per sample, FIR_LAT cycles after fir_tvalid
//   coef_err       - sticky: a partial coefficient load was aborted by a sample
//   busy           - not IDLE, or results still in flight
//   dbg_state      - current sequencer state
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int X_N_SIZE     = X_N_SIZE_DEF,
  parameter int Y_N_SIZE     = Y_N_SIZE_DEF,
  parameter int NBR_OF_TAPS  = NBR_OF_TAPS_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int LAT          = FIR_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_seq_ctrl_if.slave       host,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                fir_reset,
  input  logic [Y_N_SIZE-1:0] fir_y_n,
  output logic [Y_N_SIZE-1:0] out_data,
  output logic                out_valid,
  output logic                coef_err,
  output logic                busy,
  output fir_state_e          dbg_state
);

  localparam int CNT_W  = $clog2(NBR_OF_TAPS + 1);
  localparam int INIT_W = $clog2(SETUP_CYCLES + 1);

  fir_state_e          state_q, state_d;
  logic [CNT_W-1:0]    coef_cnt_q, coef_cnt_d, coef_cnt_inc;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                coef_err_q, coef_err_d;
  logic                in_ready_q, in_ready_d;
  logic [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                tvalid_q, tvalid_d;
  logic                set_q, set_d;
  logic                fir_reset_q;
  logic                accept;
  logic                dly_out, dly_any;

  assign accept = host.in_valid & in_ready_q;

  // Saturating increment: the counter can never wrap past NBR_OF_TAPS.
  assign coef_cnt_inc = (coef_cnt_q == CNT_W'(NBR_OF_TAPS)) ? coef_cnt_q
                                                            : coef_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    init_cnt_d = init_cnt_q;
    coef_err_d = coef_err_q;

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(SETUP_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      // IDLE and STREAM react identically to an accepted word; a STREAM
      // cycle without one falls back to IDLE so the FIR sees a tvalid gap.
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (host.in_is_coef) begin
            if (NBR_OF_TAPS == 1) begin
              state_d    = ST_IDLE;
              coef_cnt_d = '0;
            end else begin
              state_d    = ST_LOAD;
              coef_cnt_d = CNT_W'(1);
            end
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (host.in_is_coef) begin
            if (coef_cnt_inc == CNT_W'(NBR_OF_TAPS)) begin
              state_d    = ST_IDLE;
              coef_cnt_d = '0;
            end else begin
              coef_cnt_d = coef_cnt_inc;
            end
          end else begin
            // Sample interrupts a partial load: flag it, forward the sample.
            coef_err_d = 1'b1;
            coef_cnt_d = '0;
            state_d    = ST_STREAM;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    in_ready_d = (state_d != ST_INIT);
    x_n_d      = accept ? host.in_data : x_n_q;
    set_d      = accept & host.in_is_coef;
    tvalid_d   = accept & ~host.in_is_coef;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      coef_cnt_q  <= '0;
      init_cnt_q  <= '0;
      coef_err_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      x_n_q       <= '0;
      tvalid_q    <= 1'b0;
      set_q       <= 1'b0;
      fir_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      coef_cnt_q  <= coef_cnt_d;
      init_cnt_q  <= init_cnt_d;
      coef_err_q  <= coef_err_d;
      in_ready_q  <= in_ready_d;
      x_n_q       <= x_n_d;
      tvalid_q    <= tvalid_d;
      set_q       <= set_d;
      // FIR reset covers only the first cycle after rst_n release.
      fir_reset_q <= 1'b0;
    end
  end

  // Reset empties the result pipeline so no stale result can emerge.
  fir_valid_delay #(.DEPTH(LAT)) u_valid_delay (
    .clk   (clk),
    .clr_i (~rst_n),
    .in_i  (tvalid_q),
    .out_o (dly_out),
    .any_o (dly_any)
  );

  assign host.in_ready  = in_ready_q;
  assign fir_x_n        = x_n_q;
  assign fir_tvalid     = tvalid_q;
  assign fir_set_coeffs = set_q;
  assign fir_reset      = fir_reset_q;
  assign coef_err       = coef_err_q;
  assign out_valid      = dly_out;
  // y_n is only valid in the cycle the delayed strobe arrives, so it is
  // passed through in that cycle rather than registered a cycle late.
  assign out_data       = dly_out ? fir_y_n : '0;
  assign busy           = (state_q != ST_IDLE) | dly_any;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;

  localparam int X = 8;
  localparam int Y = 11;
  localparam int N = 3;
  localparam int S = 4;
  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.X_N_SIZE(X)) host_if ();

  logic [X-1:0] fir_x_n;
  logic         fir_tvalid, fir_set_coeffs, fir_reset;
  logic [Y-1:0] fir_y_n;
  logic [Y-1:0] out_data;
  logic         out_valid, coef_err, busy;
  logic [1:0]   dbg_state;

  fir_seq_ctrl #(
    .X_N_SIZE(X), .Y_N_SIZE(Y), .NBR_OF_TAPS(N), .SETUP_CYCLES(S), .LAT(L)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host           (host_if),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .fir_reset      (fir_reset),
    .fir_y_n        (fir_y_n),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .coef_err       (coef_err),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIR output is free-running noise; the bench knows what it drove.
  always @(posedge clk) begin
    #1;
    fir_y_n = Y'($urandom);
  end

  // ---------------- behavioural model ----------------
  // Tracks the abstract situation: setup cycles left, coefficients of the
  // current load, whether the previous cycle forwarded a sample, and the
  // cycle numbers at which each forwarded sample's result is due.
  bit           model_ok = 1'b0;
  int           cyc = 0;
  int           setup_left, loaded;
  bit           prev_sample;
  logic [X-1:0] e_x;
  bit           e_tv, e_set, e_rst, e_rdy, e_err;
  int           exp_q[$];

  always @(posedge clk) begin : model
    bit acc;
    if (!rst_n) begin
      model_ok    = 1'b1;
      setup_left  = S;
      loaded      = 0;
      prev_sample = 1'b0;
      e_x = '0; e_tv = 0; e_set = 0; e_rst = 1; e_rdy = 0; e_err = 0;
      exp_q.delete();
      cyc++;
    end else if (model_ok) begin
      acc = host_if.in_valid && e_rdy;
      cyc++;
      e_rst = 0;
      if (setup_left > 0) setup_left--;
      e_rdy = (setup_left == 0);
      e_set = 0; e_tv = 0; prev_sample = 0;
      if (acc) begin
        e_x = host_if.in_data;
        if (host_if.in_is_coef) begin
          e_set = 1;
          loaded++;
          if (loaded == N) loaded = 0;
        end else begin
          e_tv = 1;
          if (loaded > 0) e_err = 1;
          loaded = 0;
          prev_sample = 1;
          exp_q.push_back(cyc + L);
        end
      end
      while (exp_q.size() > 0 && exp_q[0] < cyc) void'(exp_q.pop_front());
    end
  end

  // ---------------- compare process ----------------
  int cnt_set = 0, cnt_tv = 0, cnt_ov = 0;

  always @(negedge clk) begin : compare
    bit e_ov, pend;
    if (model_ok && !done) begin
      e_ov = 0; pend = 0;
      foreach (exp_q[i]) begin
        if (exp_q[i] == cyc) e_ov = 1;
        if (exp_q[i] >= cyc && exp_q[i] - L < cyc) pend = 1;
      end
      chk("in_ready",   host_if.in_ready, e_rdy);
      chk("fir_x_n",    fir_x_n,          e_x);
      chk("fir_tvalid", fir_tvalid,       e_tv);
      chk("set_coeffs", fir_set_coeffs,   e_set);
      chk("fir_reset",  fir_reset,        e_rst);
      chk("coef_err",   coef_err,         e_err);
      chk("strobe_excl", fir_tvalid & fir_set_coeffs, 0);
      chk("busy", busy, (setup_left > 0) || (loaded > 0) || prev_sample || pend);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) chk("out_data", out_data, fir_y_n);
    end
    cnt_set += fir_set_coeffs;
    cnt_tv  += fir_tvalid;
    cnt_ov  += out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [X-1:0] d, input bit c);
    host_if.in_valid   = v;
    host_if.in_data    = d;
    host_if.in_is_coef = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    host_if.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_counts();
    cnt_set = 0; cnt_tv = 0; cnt_ov = 0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    host_if.in_valid = 1'b0; host_if.in_data = '0; host_if.in_is_coef = 1'b0;
    fir_y_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x_n", fir_x_n, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_state", dbg_state, 2'b00);

    // Release with in_valid held high: nothing may be accepted during setup.
    rst_n = 1'b1;
    host_if.in_valid = 1'b1; host_if.in_data = 8'hAA; host_if.in_is_coef = 1'b0;
    for (int k = 0; k <= S; k++) begin
      if (k == S) host_if.in_valid = 1'b0;
      @(negedge clk);
      if (k == 0) chk("fir_reset_first", fir_reset, 1);
      if (k == 1) chk("fir_reset_drop", fir_reset, 0);
      chk("setup_ready", host_if.in_ready, (k == S));
      chk("setup_no_strobe", fir_tvalid | fir_set_coeffs, 0);
      @(posedge clk); #1;
    end
    chk("setup_idle", dbg_state, 2'b01);

    // Back-to-back full load.
    clr_counts();
    drive(1, 8'h01, 1); drive(1, 8'h07, 1); drive(1, 8'h00, 1);
    idle(2);
    chk("load3_pulses", cnt_set, 3);
    chk("load3_err", coef_err, 0);
    chk("load3_idle", dbg_state, 2'b01);

    // Load with a stall in the middle.
    clr_counts();
    drive(1, 8'h03, 1); drive(0, 8'h55, 1); drive(1, 8'h05, 1); drive(1, 8'h02, 1);
    idle(2);
    chk("stall_pulses", cnt_set, 3);
    chk("stall_idle", dbg_state, 2'b01);

    // Contiguous samples and their results.
    clr_counts();
    drive(1, 8'd10, 0); drive(1, 8'd20, 0); drive(1, 8'd30, 0);
    idle(L + 3);
    chk("stream_tvalid", cnt_tv, 3);
    chk("stream_results", cnt_ov, 3);
    chk("stream_idle_busy", busy, 0);

    // Aborted load sets the sticky error.
    drive(1, 8'h01, 1); drive(1, 8'h10, 0);
    idle(1);
    chk("abort_err", coef_err, 1);
    drive(1, 8'h11, 1); drive(1, 8'h22, 1); drive(1, 8'h33, 1);
    idle(L + 2);
    chk("abort_err_sticky", coef_err, 1);

    // Reset mid-stream with results in flight.
    drive(1, 8'h41, 0); drive(1, 8'h42, 0); drive(1, 8'h43, 0); drive(1, 8'h44, 0);
    host_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    clr_counts();
    chk("midrst_state", dbg_state, 2'b00);
    chk("midrst_fir_reset", fir_reset, 1);
    chk("midrst_busy", busy, 1);
    rst_n = 1'b1;
    idle(S + L + 3);
    chk("midrst_no_result", cnt_ov, 0);
    chk("midrst_err_clear", coef_err, 0);
    chk("midrst_back_idle", dbg_state, 2'b01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        idle($urandom_range(1, 3));
        rst_n = 1'b1;
      end else begin
        drive($urandom_range(0, 3) != 0, X'($urandom), $urandom_range(0, 2) == 0);
      end
    end
    idle(L + 4);

    done = 1'b1;
    summary();
    $finish;
  end

  // Watchdog: the stimulus has no open-ended waits, but never hang.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

endmodule
